// File: rtl/mitch_pkg.sv
// Shared types and constants for the Mitchell-logarithm approximate arithmetic blocks.
package mitch_pkg;

  localparam int          W_DEFAULT = 6;
  localparam int          W_MAX     = 15;
  localparam int          Q_FRAC    = 16;
  localparam logic [31:0] DZ_VALUE  = 32'hFFFF_FFFF;

  // Mantissa is carried at the widest legal width, left-aligned; bits below W are zero.
  typedef struct packed {
    logic [3:0]       k;
    logic [W_MAX-1:0] m;
    logic             z;
  } log_t;

  function automatic logic [3:0] lead_one(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mitch_lod.sv
// Leading-one detector plus mantissa aligner: converts a 16-bit operand to truncated log form.
module mitch_lod
  import mitch_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [15:0] v,
  output log_t        l
);

  logic [15:0] frac;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    l.k  = lead_one(v);
    l.z  = (v == '0);
    frac = v << (4'd15 - l.k);
    l.m  = frac[14:0] & ~(15'h7FFF >> W);
  end

endmodule

// File: rtl/mitch_div_pipe.sv
// Three-stage pipelined Mitchell approximate divider: LOD, log subtract, antilog to Q16.16.
module mitch_div_pipe
  import mitch_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] q_out,
  output logic        dz_out,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int SHR     = W_MAX - W;
  localparam int SH_BIAS = 32 + Q_FRAC - W;

  logic en;
  log_t lx, ly;

  logic v1, v2;
  log_t s1_x, s1_y;

  logic signed [4:0] s2_kd;
  logic        [W:0] s2_d;
  logic              s2_zx, s2_zy;

  logic        [W:0] mant;
  logic signed [5:0] exp_v;
  logic        [5:0] sh;
  logic       [31:0] q_calc;
  logic       [31:0] q_next;
  logic              dz_next;

  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  mitch_lod #(.W(W)) u_lod_x (.v(x), .l(lx));
  mitch_lod #(.W(W)) u_lod_y (.v(y), .l(ly));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      q_out     <= '0;
      dz_out    <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        q_out  <= q_next;
        dz_out <= dz_next;
      end
    end
  end

  // NOTE: internal stage data needs no reset; it is only ever observed behind a cleared valid.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      s1_x <= lx;
      s1_y <= ly;
    end
    if (en && v1) begin
      s2_kd <= 5'(s1_x.k) - 5'(s1_y.k);
      s2_d  <= (W+1)'({1'b0, s1_x.m >> SHR} - {1'b0, s1_y.m >> SHR});
      s2_zx <= s1_x.z;
      s2_zy <= s1_y.z;
    end
  end

  // A negative d read as unsigned already equals 2 + d at W fraction bits.
  always_comb begin
    mant   = s2_d[W] ? s2_d : {1'b1, s2_d[W-1:0]};
    exp_v  = {s2_kd[4], s2_kd} - 6'(s2_d[W]);
    sh     = 6'(exp_v) + 6'(SH_BIAS);
    q_calc = 32'((64'(mant) << sh) >> 32);

    q_next  = q_calc;
    dz_next = 1'b0;
    if (s2_zy) begin
      q_next  = DZ_VALUE;
      dz_next = 1'b1;
    end else if (s2_zx) begin
      q_next  = '0;
    end
  end

endmodule

// File: tb/tb_mitch_div_pipe.sv
// Self-checking bench for mitch_div_pipe: directed steps plus a scoreboard queue of expected results.
module tb_mitch_div_pipe;
  import mitch_pkg::*;

  localparam int W = W_DEFAULT;

  logic        clk;
  logic        rst_n;
  logic [15:0] x, y;
  logic        in_valid, in_ready;
  logic [31:0] q_out;
  logic        dz_out, out_valid, out_ready;

  int          tests = 0;
  int          fails = 0;
  int          n_out = 0;
  int          run = 0;
  int          max_run = 0;
  logic [32:0] exp_q[$];

  mitch_div_pipe #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .in_valid(in_valid), .in_ready(in_ready),
    .q_out(q_out), .dz_out(dz_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: explicit Mitchell divide on integers.
  function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b);
    int ka, kb, ma, mb, d, kd, e, s;
    longint mant;
    logic [63:0] q;
    if (b == 0) return {1'b1, 32'hFFFF_FFFF};
    if (a == 0) return 33'd0;
    ka = 0; kb = 0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    ma = int'(a) - (1 << ka);
    mb = int'(b) - (1 << kb);
    ma = (ka >= W) ? (ma >> (ka - W)) : (ma << (W - ka));
    mb = (kb >= W) ? (mb >> (kb - W)) : (mb << (W - kb));
    d  = ma - mb;
    kd = ka - kb;
    if (d >= 0) begin mant = longint'((1 << W) + d); e = kd; end
    else        begin mant = longint'((2 << W) + d); e = kd - 1; end
    s = e + Q_FRAC - W;
    q = (s >= 0) ? (64'(mant) << s) : (64'(mant) >> (-s));
    return {1'b0, q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        check("spurious_output", 64'(exp_q.size()), 64'(1));
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result", {31'b0, dz_out, q_out}, {31'b0, e});
      end
    end else begin
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high; the caller drops it after the last operand of a burst.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [32:0] e);
    int n;
    x = a; y = b; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(n < 50), 64'(1));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic [15:0] a, input logic [15:0] b);
    send(a, b, model(a, b));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    tick();
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_before;
    logic [31:0] held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_q_out",     64'(q_out),     64'(0));
    check("rst_dz_out",    64'(dz_out),    64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    rst_n = 1'b1;
    tick();

    // Latency: accept cycle counts as cycle 0, result valid in cycle 3.
    send(16'd64, 16'd8, {1'b0, 32'h0008_0000});
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(3));
    drain();

    send(16'd100,   16'd10, {1'b0, 32'h000A_8000});
    send(16'd2,     16'd3,  {1'b0, 32'h0000_C000});
    send(16'd65535, 16'd1,  {1'b0, 32'hFE00_0000});
    send(16'h1234,  16'd0,  {1'b1, 32'hFFFF_FFFF});
    send(16'd0,     16'd0,  {1'b1, 32'hFFFF_FFFF});
    send(16'd0,     16'd5,  {1'b0, 32'h0000_0000});
    send(16'd1,     16'd65535, model(16'd1, 16'd65535));
    in_valid = 1'b0;
    drain();

    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      send_m(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)));
    end
    in_valid = 1'b0;
    drain();
    check("stream_run", 64'(max_run), 64'(8));

    // Stall: fill the pipe with out_ready low, then keep in_valid high with junk operands.
    out_ready = 1'b0;
    send_m(16'd3000, 16'd7);
    send_m(16'd9,    16'd250);
    send_m(16'd777,  16'd777);
    x = 16'hBEEF; y = 16'h0003; in_valid = 1'b1;
    held = q_out;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready",  64'(in_ready),  64'(0));
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_q_hold",    64'(q_out),     64'(held));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_m(16'd40000, 16'd3);
    in_valid = 1'b0;
    drain();

    // Reset with three operations in flight.
    send_m(16'd1000, 16'd3);
    send_m(16'd5,    16'd9);
    send_m(16'd8191, 16'd17);
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    n_before = n_out;
    tick();
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_q_out",     64'(q_out),     64'(0));
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    rst_n = 1'b1;
    repeat (8) tick();
    check("no_stale", 64'(n_out), 64'(n_before));
    send_m(16'd500, 16'd7);
    in_valid = 1'b0;
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
